// File: rtl/rs_br.sv
// rs_br: in-order reservation station for branch/jump micro-ops.
//
// Dispatched branches are buffered in a circular FIFO. Missing source operands
// are captured from two CDB broadcast ports (CDB0 has priority over CDB1). Only
// the head entry may issue, once both operands are ready and the branch unit
// can accept it. Issue fields are driven combinationally from the head entry.
//
// Optional feature macro: RS_BR_CDB_BYPASS_EN
//   defined   - a head source matching a CDB broadcast this cycle counts as ready
//               and the CDB value is forwarded to o_rs1/o_rs2 in the same cycle.
//   undefined - a waiting head issues the cycle after the broadcast.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   i_dp_*                           dispatch request and entry payload
//   o_full                           station full, dispatch refused
//   i_cdb{0,1}_{vld,tag,data}        CDB broadcast ports
//   i_flush                          kill all entries
//   i_exunit_accessable              branch unit can accept this cycle
//   o_is_vld, o_*                    issue valid and issued fields
module rs_br #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned TAG_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_dp_vld,
  output logic              o_full,
  input  logic              i_dp_is_jal,
  input  logic              i_dp_is_jalr,
  input  logic [OP_W-1:0]   i_dp_alu_op,
  input  logic [PC_W-1:0]   i_dp_pc,
  input  logic [DATA_W-1:0] i_dp_imm,
  input  logic [PC_W-1:0]   i_dp_pred_jmpaddr,
  input  logic [TAG_W-1:0]  i_dp_rob_tag,
  input  logic              i_dp_src1_rdy,
  input  logic              i_dp_src2_rdy,
  input  logic [DATA_W-1:0] i_dp_src1,
  input  logic [DATA_W-1:0] i_dp_src2,
  input  logic              i_cdb0_vld,
  input  logic              i_cdb1_vld,
  input  logic [TAG_W-1:0]  i_cdb0_tag,
  input  logic [TAG_W-1:0]  i_cdb1_tag,
  input  logic [DATA_W-1:0] i_cdb0_data,
  input  logic [DATA_W-1:0] i_cdb1_data,
  input  logic              i_flush,
  input  logic              i_exunit_accessable,
  output logic              o_is_vld,
  output logic              o_is_jal,
  output logic              o_is_jalr,
  output logic [OP_W-1:0]   o_alu_op,
  output logic [DATA_W-1:0] o_rs1,
  output logic [DATA_W-1:0] o_rs2,
  output logic [PC_W-1:0]   o_pc,
  output logic [DATA_W-1:0] o_imm,
  output logic [PC_W-1:0]   o_pred_jmpaddr,
  output logic [TAG_W-1:0]  o_rob_tag
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic              jal;
    logic              jalr;
    logic [OP_W-1:0]   alu_op;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   pred;
    logic [TAG_W-1:0]  rob_tag;
    logic              s1_rdy;
    logic              s2_rdy;
    logic [DATA_W-1:0] s1;   // value when ready, producer tag in low bits otherwise
    logic [DATA_W-1:0] s2;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  logic   [DEPTH-1:0] vld_q, vld_d;
  logic   [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic   [CntW-1:0]  cnt_q, cnt_d;

  // Returns {ready, value} for one operand after looking at both CDB ports.
  function automatic logic [DATA_W:0] wake(
    input logic              rdy,
    input logic [DATA_W-1:0] val,
    input logic              v0,
    input logic [TAG_W-1:0]  t0,
    input logic [DATA_W-1:0] d0,
    input logic              v1,
    input logic [TAG_W-1:0]  t1,
    input logic [DATA_W-1:0] d1
  );
    if (rdy)                              return {1'b1, val};
    else if (v0 && t0 == val[TAG_W-1:0])  return {1'b1, d0};
    else if (v1 && t1 == val[TAG_W-1:0])  return {1'b1, d1};
    else                                  return {1'b0, val};
  endfunction

  logic   accept, issue;
  entry_t dp_ent, head_ent;
  logic   head_s1_rdy, head_s2_rdy;
  logic [DATA_W-1:0] head_s1, head_s2;

  assign o_full   = (cnt_q == CntW'(DEPTH));
  assign accept   = i_dp_vld && !o_full && !i_flush;
  assign head_ent = ent_q[head_q];

`ifdef RS_BR_CDB_BYPASS_EN
  assign {head_s1_rdy, head_s1} = wake(head_ent.s1_rdy, head_ent.s1, i_cdb0_vld, i_cdb0_tag,
                                       i_cdb0_data, i_cdb1_vld, i_cdb1_tag, i_cdb1_data);
  assign {head_s2_rdy, head_s2} = wake(head_ent.s2_rdy, head_ent.s2, i_cdb0_vld, i_cdb0_tag,
                                       i_cdb0_data, i_cdb1_vld, i_cdb1_tag, i_cdb1_data);
`else
  assign head_s1_rdy = head_ent.s1_rdy;
  assign head_s2_rdy = head_ent.s2_rdy;
  assign head_s1     = head_ent.s1;
  assign head_s2     = head_ent.s2;
`endif

  assign issue = vld_q[head_q] && head_s1_rdy && head_s2_rdy && i_exunit_accessable && !i_flush;

  // New entry, with operands captured from a CDB broadcast in the dispatch cycle.
  always_comb begin
    dp_ent         = '0;
    dp_ent.jal     = i_dp_is_jal;
    dp_ent.jalr    = i_dp_is_jalr;
    dp_ent.alu_op  = i_dp_alu_op;
    dp_ent.pc      = i_dp_pc;
    dp_ent.imm     = i_dp_imm;
    dp_ent.pred    = i_dp_pred_jmpaddr;
    dp_ent.rob_tag = i_dp_rob_tag;
    {dp_ent.s1_rdy, dp_ent.s1} = wake(i_dp_src1_rdy, i_dp_src1, i_cdb0_vld, i_cdb0_tag,
                                      i_cdb0_data, i_cdb1_vld, i_cdb1_tag, i_cdb1_data);
    {dp_ent.s2_rdy, dp_ent.s2} = wake(i_dp_src2_rdy, i_dp_src2, i_cdb0_vld, i_cdb0_tag,
                                      i_cdb0_data, i_cdb1_vld, i_cdb1_tag, i_cdb1_data);
  end

  always_comb begin
    ent_d  = ent_q;
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q + CntW'(accept) - CntW'(issue);

    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) begin
        {ent_d[i].s1_rdy, ent_d[i].s1} = wake(ent_q[i].s1_rdy, ent_q[i].s1, i_cdb0_vld,
                                              i_cdb0_tag, i_cdb0_data, i_cdb1_vld,
                                              i_cdb1_tag, i_cdb1_data);
        {ent_d[i].s2_rdy, ent_d[i].s2} = wake(ent_q[i].s2_rdy, ent_q[i].s2, i_cdb0_vld,
                                              i_cdb0_tag, i_cdb0_data, i_cdb1_vld,
                                              i_cdb1_tag, i_cdb1_data);
      end
    end

    if (issue) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
    end

    // Tail slot is never valid when accepting, so this cannot collide with wakeup/issue.
    if (accept) begin
      vld_d[tail_q] = 1'b1;
      ent_d[tail_q] = dp_ent;
      tail_d        = tail_q + 1'b1;
    end

    if (i_flush) begin
      vld_d  = '0;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q  <= '0;
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent_q  <= ent_d;
      vld_q  <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_is_vld       = issue;
  assign o_is_jal       = head_ent.jal;
  assign o_is_jalr      = head_ent.jalr;
  assign o_alu_op       = head_ent.alu_op;
  assign o_rs1          = head_s1;
  assign o_rs2          = head_s2;
  assign o_pc           = head_ent.pc;
  assign o_imm          = head_ent.imm;
  assign o_pred_jmpaddr = head_ent.pred;
  assign o_rob_tag      = head_ent.rob_tag;

endmodule

// File: doc/rs_br.md
Name: rs_br

Overview:
- In-order reservation station for branch/jump micro-ops; sits directly upstream of the branch execution unit.
- Buffers dispatched branches and captures missing source operands from two common-data-bus (CDB) broadcast ports.
- Issues the oldest entry to the branch execution unit once both operands are ready and the unit is accessible.
- Entries are kept in program order as a circular FIFO; only the head may issue.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- DATA_W, 32, operand and immediate width.
- PC_W, 32, PC and predicted-target width.
- OP_W, 4, ALU compare-op select width.
- TAG_W, 6, ROB tag width; used as the operand-producer tag and the branch's own tag.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_dp_vld  in  1  dispatch request.
- o_full  out  1  station full; dispatch is not accepted while high.
- i_dp_is_jal, i_dp_is_jalr  in  1 each  jump type flags.
- i_dp_alu_op  in  OP_W  compare op.
- i_dp_pc  in  PC_W  branch PC.
- i_dp_imm  in  DATA_W  immediate.
- i_dp_pred_jmpaddr  in  PC_W  predicted target.
- i_dp_rob_tag  in  TAG_W  branch's ROB tag.
- i_dp_src1_rdy, i_dp_src2_rdy  in  1 each  operand already valid.
- i_dp_src1, i_dp_src2  in  DATA_W each  operand value if ready, else producer tag in the low TAG_W bits.
- i_cdb0_vld, i_cdb1_vld  in  1 each  broadcast valid.
- i_cdb0_tag, i_cdb1_tag  in  TAG_W each  producer tag.
- i_cdb0_data, i_cdb1_data  in  DATA_W each  produced value.
- i_flush  in  1  kill all entries (mispredict recovery).
- i_exunit_accessable  in  1  branch unit can accept this cycle.
- o_is_vld  out  1  issue valid.
- o_is_jal, o_is_jalr, o_alu_op, o_rs1, o_rs2, o_pc, o_imm, o_pred_jmpaddr, o_rob_tag  out  matching widths  issued fields; combinational from the head entry.

Behaviour:
- Reset: all entry valid bits 0, head = tail = 0, count = 0; o_full = 0, o_is_vld = 0; payload outputs are don't-care.
- Dispatch accept = i_dp_vld && !o_full && !i_flush.
  - Accepted entry is written at tail on the next edge; tail then increments modulo DEPTH (wraps DEPTH-1 to 0).
- Dispatch-cycle capture:
  - If a source is not ready and a valid CDB port carries the matching tag in the dispatch cycle, the entry stores that CDB data and is marked ready.
  - If both CDB ports match, CDB0 wins.
- Wakeup: every valid, not-ready source whose tag equals a valid CDB tag captures the data and becomes ready at the next edge. CDB0 has priority over CDB1.
- Issue condition: head valid && src1 ready && src2 ready && i_exunit_accessable && !i_flush.
  - o_is_vld is high exactly when the issue condition holds.
  - The head is invalidated at the edge and head increments modulo DEPTH.
  - Latency: an entry dispatched with both operands ready, into an empty station, issues the cycle after dispatch (it becomes head at that edge).
- Count and full:
  - count_next = count + accept − issue.
  - o_full = (count == DEPTH), registered from count.
  - When full, dispatch is refused even if an issue occurs in the same cycle.
- Flush: clears all valid bits and resets head, tail and count to 0 at the next edge. Same-cycle dispatch is dropped and same-cycle issue is suppressed (o_is_vld = 0).
- Reset asserted mid-operation clears state immediately (asynchronous); outputs go low without waiting for a clock edge.
- Entries never reorder; a non-ready head blocks younger ready entries.

Optional Feature:
- Macro: RS_BR_CDB_BYPASS_EN.
- Defined: the issue condition also treats a head source as ready if a valid CDB tag matches it this cycle. o_rs1/o_rs2 forward the CDB data combinationally (CDB0 priority), so issue happens in the same cycle as the wakeup.
- Undefined: no forwarding; a head waiting on a CDB issues the cycle after the broadcast, using the captured value.

Test Plan:
- Dispatch pc=0x100, imm=0x8, src1=5 and src2=5 both ready, alu_op=BEQ into an empty station, unit accessible → o_is_vld=1 next cycle with o_pc=0x100, o_rs1=o_rs2=5, correct o_rob_tag; count returns to 0.
- Dispatch with src1 waiting on tag 7 → no issue. CDB1 broadcasts tag 7 with data 0x55 → issue with o_rs1=0x55 one cycle later (bypass off) or the same cycle (bypass on).
- Dispatch 4 entries with operands unready → o_full=1. A 5th dispatch is ignored. Wake all four → they issue in dispatch order; tail and head wrap to 0; o_full deasserts after the first issue.
- CDB0 and CDB1 both carry tag 3 (data 0xA and 0xB) while an entry waits on tag 3 → captured value is 0xA.
- i_exunit_accessable=0 with a ready head → o_is_vld=0 and the entry is held. Raise it → issue with unchanged fields.
- i_flush while 3 entries are valid and a dispatch is requested → next cycle count=0, o_full=0, no issue. Assert rst between edges → o_is_vld drops immediately.
